sample_iterator: RTL and testbench
==================================

# sample_iterator

Transmitting end of the sample stream consumed by the rasterizer's sample-test stage. Accepts one bounding-boxed triangle at a time from the bounding-box stage, walks every sample position inside the box in raster order at the selected MSAA rate, and emits one sample location per cycle together with the held triangle and color. Upstream is stalled through an active-low halt while a box is being walked.

## Interface
- SIGFIG, 24, bits in color and position
- RADIX, 10, fraction bits in color and position
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, color channels
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- tri_R13S  in  signed [SIGFIG-1:0] [VERTS][AXIS]  triangle from bounding-box stage
- color_R13U  in  [SIGFIG-1:0] [COLORS]  triangle color
- box_R13S  in  signed [SIGFIG-1:0] [2][2]  box corners; [0]=lower-left, [1]=upper-right; [.][0]=x, [.][1]=y
- validTri_R13H  in  1  triangle/box valid
- subSample_RnnnnU  in  [3:0]  one-hot MSAA rate: 4'b1000=1x, 0100=4x, 0010=16x, 0001=64x
- halt_RnnnnL  out  1  low = upstream must hold; high = ready
- tri_R14S  out  signed [SIGFIG-1:0] [VERTS][AXIS]  held triangle
- color_R14U  out  [SIGFIG-1:0] [COLORS]  held color
- sample_R14S  out  signed [SIGFIG-1:0] [2]  sample location (x,y)
- validSamp_R14H  out  1  sample_R14S valid

## Operation
- Step size: 1x = 1<<RADIX, 4x = 1<<(RADIX-1), 16x = 1<<(RADIX-2), 64x = 1<<(RADIX-3). subSample_RnnnnU is static while not in WAIT; non-one-hot values are illegal.
- FSM states WAIT, TEST.
- WAIT: halt_RnnnnL=1, validSamp_R14H=0. Accept when validTri_R13H && halt_RnnnnL: latch tri, color, box, step; sample_R14S <= box LL; validSamp_R14H <= 1; go TEST.
- TEST: halt_RnnnnL=0, validSamp_R14H=1. Each cycle advance:
  - at_end_x = (x + step > UR_x); at_end_y = (y + step > UR_y), evaluated in SIGFIG+1 bits signed (no overflow wrap).
  - !at_end_x: x += step.
  - at_end_x && !at_end_y: x <= LL_x, y += step.
  - at_end_x && at_end_y: last sample; next cycle validSamp=0, halt=1, state WAIT.
- Sample count per box = ((URx-LLx)/step+1)*((URy-LLy)/step+1), integer floor.
- Box with UR<LL on an axis: that axis yields exactly one position (LL).
- validTri_R13H in TEST ignored (upstream holds because halt low).
- tri_R14S/color_R14U stable for the whole walk; updated only on acceptance.
- No downstream backpressure; downstream pipeline is fixed-latency.

## Timing
- Reset values: state WAIT, halt_RnnnnL=1, validSamp_R14H=0, sample_R14S=0, tri_R14S=0, color_R14U=0, LFSR=16'hACE1 (when enabled).
- All outputs registered.
- Acceptance at edge N -> first sample valid in cycle N+1; box of K samples -> validSamp high cycles N+1..N+K, halt low same cycles; cycle N+K+1 halt high, earliest next acceptance at N+K+1, so one bubble between triangles.
- Reset asserted mid-walk: next cycle all outputs at reset values; current triangle discarded.

## Configuration
- SAMPLE_JITTER_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances once per emitted sample; emitted x adds lfsr[7:0] masked to (step-1), y adds lfsr[15:8] masked to (step-1), both zero-extended to SIGFIG and placed in the low fraction bits. Walk counters use unjittered positions; only sample_R14S is offset. At 1x with RADIX=10 the mask is 10 bits wide; the upper two bits of that mask come from zero. LFSR reset to 16'hACE1.
- Undefined: no LFSR, sample_R14S equals the unjittered grid position.

## Test plan
- Reset: rst high 2 cycles -> halt_RnnnnL=1, validSamp_R14H=0, sample_R14S=(0,0).
- 1x, box LL=(0,0) UR=(0x400,0x400): accept at N -> samples (0,0),(0x400,0),(0,0x400),(0x400,0x400) in N+1..N+4; halt low exactly those cycles; N+5 halt=1, valid=0.
- 4x, box LL=UR=(0x800,0xC00): exactly one sample (0x800,0xC00), then WAIT.
- 64x, box LL=(0,0) UR=(0x3FF,0): 8 samples x=0,0x80,...,0x380, y=0.
- Back-to-back: validTri held high across two triangles -> second accepted the cycle halt returns high; its first sample follows one bubble with new tri_R14S.
- Reset at 2nd sample of a 4-sample walk -> next cycle valid=0, halt=1; new triangle then walks from its LL.

Source files
------------

// File: rtl/sample_iterator.sv
`default_nettype none
// ============================================================================
// Module      : sample_iterator
// Description : Transmitting end of the rasterizer sample stream. Accepts one
//               bounding-boxed triangle, walks every sample position inside
//               the box in raster order at the selected MSAA rate and emits
//               one sample location per cycle with the held triangle/color.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               tri_R13S, color_R13U, box_R13S, validTri_R13H
//                                   - triangle/color/box from bbox stage
//               subSample_RnnnnU    - one-hot MSAA rate (1x/4x/16x/64x)
//               halt_RnnnnL         - low while a box is being walked
//               tri_R14S, color_R14U- triangle/color held for the walk
//               sample_R14S         - sample location (x,y)
//               validSamp_R14H      - sample_R14S valid
// Config      : SAMPLE_JITTER_EN    - adds LFSR jitter to emitted samples
// Revision    : 1.0 - initial release
// ============================================================================
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S    [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U  [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S    [2][2],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U  [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2],
    output logic                     validSamp_R14H
);

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_TEST = 1'b1
    } state_t;

    localparam logic [SIGFIG-1:0] STEP_1X  = SIGFIG'(1 << RADIX);
    localparam logic [SIGFIG-1:0] STEP_4X  = SIGFIG'(1 << (RADIX - 1));
    localparam logic [SIGFIG-1:0] STEP_16X = SIGFIG'(1 << (RADIX - 2));
    localparam logic [SIGFIG-1:0] STEP_64X = SIGFIG'(1 << (RADIX - 3));

    state_t                   state_q, state_d;
    logic                     halt_q, halt_d;
    logic                     valid_q, valid_d;
    logic signed [SIGFIG-1:0] x_q, x_d, y_q, y_d;         // unjittered grid
    logic signed [SIGFIG-1:0] llx_q, llx_d, urx_q, urx_d, ury_q, ury_d;
    logic        [SIGFIG-1:0] step_q, step_d;
    logic signed [SIGFIG-1:0] sx_q, sx_d, sy_q, sy_d;     // emitted sample
    logic signed [SIGFIG-1:0] tri_q   [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_q [COLORS];

    logic                     w_accept;
    logic        [SIGFIG-1:0] w_step_sel;
    logic signed [SIGFIG:0]   w_x_adv, w_y_adv;
    logic                     w_end_x, w_end_y;
    logic        [SIGFIG-1:0] w_jx, w_jy;

    // Illegal (non-one-hot) rates fall back to 1x.
    always_comb begin
        w_step_sel = STEP_1X;
        case (subSample_RnnnnU)
            4'b1000: w_step_sel = STEP_1X;
            4'b0100: w_step_sel = STEP_4X;
            4'b0010: w_step_sel = STEP_16X;
            4'b0001: w_step_sel = STEP_64X;
            default: w_step_sel = STEP_1X;
        endcase
    end

    // One extra bit so a position near the top of the range cannot wrap
    // past the upper-right corner.
    assign w_x_adv = $signed({x_q[SIGFIG-1], x_q}) + $signed({1'b0, step_q});
    assign w_y_adv = $signed({y_q[SIGFIG-1], y_q}) + $signed({1'b0, step_q});
    assign w_end_x = w_x_adv > $signed({urx_q[SIGFIG-1], urx_q});
    assign w_end_y = w_y_adv > $signed({ury_q[SIGFIG-1], ury_q});

    always_comb begin
        state_d  = state_q;
        halt_d   = halt_q;
        valid_d  = valid_q;
        x_d      = x_q;
        y_d      = y_q;
        llx_d    = llx_q;
        urx_d    = urx_q;
        ury_d    = ury_q;
        step_d   = step_q;
        w_accept = 1'b0;
        case (state_q)
            ST_WAIT: begin
                halt_d  = 1'b1;
                valid_d = 1'b0;
                if (validTri_R13H && halt_q) begin
                    w_accept = 1'b1;
                    step_d   = w_step_sel;
                    llx_d    = box_R13S[0][0];
                    urx_d    = box_R13S[1][0];
                    ury_d    = box_R13S[1][1];
                    x_d      = box_R13S[0][0];
                    y_d      = box_R13S[0][1];
                    valid_d  = 1'b1;
                    halt_d   = 1'b0;
                    state_d  = ST_TEST;
                end
            end
            ST_TEST: begin
                halt_d  = 1'b0;
                valid_d = 1'b1;
                if (!w_end_x) begin
                    x_d = w_x_adv[SIGFIG-1:0];
                end else if (!w_end_y) begin
                    x_d = llx_q;
                    y_d = w_y_adv[SIGFIG-1:0];
                end else begin
                    halt_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

`ifdef SAMPLE_JITTER_EN
    logic [15:0]       lfsr_q, lfsr_d;
    logic [SIGFIG-1:0] w_mask;

    // Jitter uses the LFSR value current when the sample is loaded; the
    // LFSR then steps so each emitted sample sees a fresh value.
    always_comb begin
        w_mask = step_d - SIGFIG'(1);
        w_jx   = {{(SIGFIG-8){1'b0}}, lfsr_q[7:0]}  & w_mask;
        w_jy   = {{(SIGFIG-8){1'b0}}, lfsr_q[15:8]} & w_mask;
        lfsr_d = lfsr_q;
        if (valid_d) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign w_jx = '0;
    assign w_jy = '0;
`endif

    // The emitted sample only moves when a new sample is presented, so it
    // holds its last value while idle.
    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        if (valid_d) begin
            sx_d = x_d + $signed(w_jx);
            sy_d = y_d + $signed(w_jy);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT;
            halt_q  <= 1'b1;
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            llx_q   <= '0;
            urx_q   <= '0;
            ury_q   <= '0;
            step_q  <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            for (int v = 0; v < VERTS; v++)
                for (int a = 0; a < AXIS; a++)
                    tri_q[v][a] <= '0;
            for (int c = 0; c < COLORS; c++)
                color_q[c] <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            llx_q   <= llx_d;
            urx_q   <= urx_d;
            ury_q   <= ury_d;
            step_q  <= step_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            if (w_accept) begin
                tri_q   <= tri_R13S;
                color_q <= color_R13U;
            end
        end
    end

    assign halt_RnnnnL    = halt_q;
    assign validSamp_R14H = valid_q;
    assign sample_R14S[0] = sx_q;
    assign sample_R14S[1] = sy_q;
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_iterator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_iterator
// Description : Self-checking bench for sample_iterator. Stimulus pushes the
//               hand-computed sample sequence into a scoreboard queue; a
//               monitor pops and compares each presented sample.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_iterator;

    localparam int SIGFIG = 24;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic signed [SIGFIG-1:0] tri_in   [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_in [COLORS];
    logic signed [SIGFIG-1:0] box_in   [2][2];
    logic                     valid_tri;
    logic        [3:0]        sub;
    logic                     halt;
    logic signed [SIGFIG-1:0] tri_out   [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_out [COLORS];
    logic signed [SIGFIG-1:0] samp_out  [2];
    logic                     valid_samp;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic signed [SIGFIG-1:0] x;
        logic signed [SIGFIG-1:0] y;
        int                       tag;
    } exp_t;
    exp_t sb[$];

    sample_iterator dut (
        .clk             (clk),
        .rst             (rst),
        .tri_R13S        (tri_in),
        .color_R13U      (color_in),
        .box_R13S        (box_in),
        .validTri_R13H   (valid_tri),
        .subSample_RnnnnU(sub),
        .halt_RnnnnL     (halt),
        .tri_R14S        (tri_out),
        .color_R14U      (color_out),
        .sample_R14S     (samp_out),
        .validSamp_R14H  (valid_samp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int x, input int y, input int tag);
        exp_t e;
        e.x   = SIGFIG'(x);
        e.y   = SIGFIG'(y);
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic load(input int llx, input int lly, input int urx, input int ury,
                        input logic [3:0] s, input int tag);
        box_in[0][0] = SIGFIG'(llx);
        box_in[0][1] = SIGFIG'(lly);
        box_in[1][0] = SIGFIG'(urx);
        box_in[1][1] = SIGFIG'(ury);
        sub = s;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_in[v][a] = SIGFIG'(tag * 16 + v * 3 + a);
        for (int c = 0; c < COLORS; c++)
            color_in[c] = SIGFIG'(tag * 256 + c);
    endtask

    // Present for one edge; returns on the negedge after acceptance.
    task automatic issue(input int llx, input int lly, input int urx, input int ury,
                         input logic [3:0] s, input int tag);
        @(negedge clk);
        load(llx, lly, urx, ury, s, tag);
        valid_tri = 1'b1;
        @(negedge clk);
        valid_tri = 1'b0;
    endtask

    task automatic expect_walk(input int k);
        for (int i = 0; i < k; i++) begin
            chk("halt_walk", longint'(halt), 0);
            chk("valid_walk", longint'(valid_samp), 1);
            @(negedge clk);
        end
        chk("halt_idle", longint'(halt), 1);
        chk("valid_idle", longint'(valid_samp), 0);
    endtask

    // Monitor: every presented sample must match the head of the scoreboard.
    always @(negedge clk) begin
        if (valid_samp) begin
            if (sb.size() == 0) begin
                chk("unexpected_sample", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sample_x", longint'(samp_out[0]), longint'(e.x));
                chk("sample_y", longint'(samp_out[1]), longint'(e.y));
                chk("tri_tag", longint'(tri_out[0][0]), longint'(e.tag * 16));
                chk("color_tag", longint'(color_out[2]), longint'(e.tag * 256 + 2));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        valid_tri = 1'b0;
        load(0, 0, 0, 0, 4'b1000, 0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_halt", longint'(halt), 1);
        chk("rst_valid", longint'(valid_samp), 0);
        chk("rst_sx", longint'(samp_out[0]), 0);
        chk("rst_sy", longint'(samp_out[1]), 0);
        chk("rst_tri", longint'(tri_out[1][1]), 0);
        rst = 1'b0;

        // 1x 2x2 box
        push(0, 0, 1); push('h400, 0, 1); push(0, 'h400, 1); push('h400, 'h400, 1);
        issue(0, 0, 'h400, 'h400, 4'b1000, 1);
        expect_walk(4);

        // 4x degenerate single-point box
        push('h800, 'hC00, 2);
        issue('h800, 'hC00, 'h800, 'hC00, 4'b0100, 2);
        expect_walk(1);

        // 64x single row of 8
        for (int i = 0; i < 8; i++) push(i * 'h80, 0, 3);
        issue(0, 0, 'h3FF, 0, 4'b0001, 3);
        expect_walk(8);

        // 16x negative x, y inverted (UR<LL) -> one row
        push(-'h200, 'h500, 4); push(-'h100, 'h500, 4);
        issue(-'h200, 'h500, -'h100, 'h100, 4'b0010, 4);
        expect_walk(2);

        // Back-to-back with validTri held high
        push(0, 0, 5); push('h400, 0, 5); push('h400, 'h400, 6);
        @(negedge clk);
        load(0, 0, 'h400, 0, 4'b1000, 5);
        valid_tri = 1'b1;
        @(negedge clk);
        load('h400, 'h400, 'h400, 'h400, 4'b1000, 6);
        chk("b2b_halt1", longint'(halt), 0);
        @(negedge clk);
        chk("b2b_halt2", longint'(halt), 0);
        @(negedge clk);
        chk("b2b_bubble_halt", longint'(halt), 1);
        chk("b2b_bubble_valid", longint'(valid_samp), 0);
        @(negedge clk);
        valid_tri = 1'b0;
        chk("b2b_second_valid", longint'(valid_samp), 1);
        chk("b2b_second_tri", longint'(tri_out[2][2]), 6 * 16 + 8);
        @(negedge clk);
        chk("b2b_end_halt", longint'(halt), 1);
        chk("b2b_end_valid", longint'(valid_samp), 0);

        // Reset during the 2nd sample of a 4-sample walk
        push(0, 0, 7); push('h400, 0, 7);
        issue(0, 0, 'h400, 'h400, 4'b1000, 7);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", longint'(valid_samp), 0);
        chk("mid_rst_halt", longint'(halt), 1);
        chk("mid_rst_sx", longint'(samp_out[0]), 0);
        chk("mid_rst_tri", longint'(tri_out[0][0]), 0);
        push('h800, 'h800, 8);
        issue('h800, 'h800, 'h800, 'h800, 4'b1000, 8);
        expect_walk(1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", longint'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
